// File: rtl/mmu_port_arb.sv
// mmu_port_arb: fixed-priority NPORT requester arbiter onto one TLB-translated memory bus.
// Define MMU_ARB_RMW_EN to serve partial writes by read-modify-write for word-only memories.
module mmu_port_arb #(
  parameter  int NPORT   = 2,
  parameter  int AW      = 32,
  parameter  int DW      = 32,
  parameter  int SELW    = 16,
  parameter  int TIMEOUT = 255,
  localparam int BW      = DW / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NPORT-1:0]      req_i,
  input  logic [NPORT-1:0]      we_i,
  input  logic [NPORT*AW-1:0]   addr_i,
  input  logic [NPORT*DW-1:0]   wdata_i,
  input  logic [NPORT*BW-1:0]   be_i,
  output logic [DW-1:0]         rdata_o,
  output logic [NPORT-1:0]      ack_o,
  output logic                  err_o,
  output logic [NPORT-1:0]      stall_o,
  output logic [AW-1:0]         tlb_vaddr_o,
  input  logic [AW-1:0]         tlb_paddr_i,
  input  logic [SELW-1:0]       tlb_dsel_i,
  output logic                  bus_cyc_o,
  output logic                  bus_we_o,
  output logic [AW-1:0]         bus_addr_o,
  output logic [DW-1:0]         bus_data_o,
  output logic [SELW-1:0]       bus_sel_o,
  output logic [BW-1:0]         bus_be_o,
  input  logic [DW-1:0]         bus_data_i,
  input  logic                  bus_ack_i
);

  localparam int              GW      = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int              TW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit              TO_EN   = (TIMEOUT != 0);
  localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]   CNT_ONE = TW'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_XLATE  = 3'd1,
    ST_ACCESS = 3'd2,
`ifdef MMU_ARB_RMW_EN
    ST_RMW_RD = 3'd3,
    ST_TURN   = 3'd4,
    ST_RMW_WR = 3'd5,
`endif
    ST_DONE   = 3'd6
  } state_t;

  state_t            state_r, state_nx_s;
  logic [GW-1:0]     gnt_s, gnt_r;
  logic              gnt_vld_s;
  logic [NPORT-1:0]  pend_s;
  logic [AW-1:0]     sel_addr_s;
  logic [DW-1:0]     sel_wdata_s;
  logic [BW-1:0]     sel_be_s;

  logic              we_r;
  logic [AW-1:0]     vaddr_r;
  logic [DW-1:0]     wdata_r;
  logic [BW-1:0]     be_r;
  logic [AW-1:0]     paddr_r, paddr_nx_s;
  logic [SELW-1:0]   dsel_r, dsel_nx_s;
  logic [DW-1:0]     rbuf_r, rbuf_nx_s;
  logic              errb_r, errb_nx_s;
  logic [TW-1:0]     cnt_r, cnt_nx_s;
  logic              in_bus_s, tmo_s;
  logic              be_none_s, be_full_s;

  logic [NPORT-1:0]  ack_r, ack_nx_s;
  logic              err_r;
  logic [DW-1:0]     rdata_r;
  logic              bus_cyc_r, bus_cyc_nx_s;
  logic              bus_we_r, bus_we_nx_s;
  logic [AW-1:0]     bus_addr_r, bus_addr_nx_s;
  logic [DW-1:0]     bus_data_r, bus_data_nx_s;
  logic [SELW-1:0]   bus_sel_r, bus_sel_nx_s;
  logic [BW-1:0]     bus_be_r, bus_be_nx_s;

`ifdef MMU_ARB_RMW_EN
  logic [DW-1:0]     wbuf_r, wbuf_nx_s;

  function automatic logic [DW-1:0] merge_lanes(input logic [DW-1:0] wd,
                                                input logic [DW-1:0] rd,
                                                input logic [BW-1:0] be);
    logic [DW-1:0] m;
    for (int l = 0; l < BW; l++) begin
      m[l*8 +: 8] = be[l] ? wd[l*8 +: 8] : rd[l*8 +: 8];
    end
    return m;
  endfunction
`endif

  assign sel_addr_s  = addr_i[int'(gnt_s)*AW +: AW];
  assign sel_wdata_s = wdata_i[int'(gnt_s)*DW +: DW];
  assign sel_be_s    = be_i[int'(gnt_s)*BW +: BW];
  assign be_none_s   = ~|be_r;
  assign be_full_s   = &be_r;
  assign paddr_nx_s  = (state_r == ST_XLATE) ? tlb_paddr_i : paddr_r;
  assign dsel_nx_s   = (state_r == ST_XLATE) ? tlb_dsel_i  : dsel_r;

  // Grant the highest-index request not being acknowledged this cycle.
  always_comb begin
    pend_s    = req_i & ~ack_r;
    gnt_s     = {GW{1'b0}};
    gnt_vld_s = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      gnt_s     = pend_s[i] ? GW'(i) : gnt_s;
      gnt_vld_s = gnt_vld_s | pend_s[i];
    end
  end

  // Bus-wait counter: restarts on entry to each bus state, counts unacknowledged cycles.
  always_comb begin
    in_bus_s = (state_r == ST_ACCESS);
`ifdef MMU_ARB_RMW_EN
    in_bus_s = in_bus_s || (state_r == ST_RMW_RD) || (state_r == ST_RMW_WR);
`endif
    tmo_s = TO_EN && in_bus_s && !bus_ack_i && (cnt_r == TO_LAST);
    if (in_bus_s && (state_nx_s == state_r)) begin
      cnt_nx_s = cnt_r + CNT_ONE;
    end else begin
      cnt_nx_s = {TW{1'b0}};
    end
  end

  // Next state plus read-data and error buffers.
  always_comb begin
    state_nx_s = state_r;
    rbuf_nx_s  = rbuf_r;
    errb_nx_s  = errb_r;
`ifdef MMU_ARB_RMW_EN
    wbuf_nx_s  = wbuf_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (gnt_vld_s) begin
          state_nx_s = ST_XLATE;
          rbuf_nx_s  = {DW{1'b0}};
          errb_nx_s  = 1'b0;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_XLATE: begin
        if (we_r && be_none_s) begin
          state_nx_s = ST_DONE;
        end else if (!we_r || be_full_s) begin
          state_nx_s = ST_ACCESS;
        end else begin
`ifdef MMU_ARB_RMW_EN
          state_nx_s = ST_RMW_RD;
`else
          state_nx_s = ST_ACCESS;
`endif
        end
      end
      ST_ACCESS: begin
        if (bus_ack_i) begin
          rbuf_nx_s  = we_r ? {DW{1'b0}} : bus_data_i;
          state_nx_s = ST_DONE;
        end else if (tmo_s) begin
          rbuf_nx_s  = {DW{1'b0}};
          errb_nx_s  = 1'b1;
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_ACCESS;
        end
      end
`ifdef MMU_ARB_RMW_EN
      ST_RMW_RD: begin
        if (bus_ack_i) begin
          wbuf_nx_s  = merge_lanes(wdata_r, bus_data_i, be_r);
          rbuf_nx_s  = merge_lanes(wdata_r, bus_data_i, be_r);
          state_nx_s = ST_TURN;
        end else if (tmo_s) begin
          rbuf_nx_s  = {DW{1'b0}};
          errb_nx_s  = 1'b1;
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_RMW_RD;
        end
      end
      ST_TURN: begin
        state_nx_s = ST_RMW_WR;
      end
      ST_RMW_WR: begin
        if (bus_ack_i) begin
          state_nx_s = ST_DONE;
        end else if (tmo_s) begin
          rbuf_nx_s  = {DW{1'b0}};
          errb_nx_s  = 1'b1;
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_RMW_WR;
        end
      end
`endif
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Bus strobes follow the next state so the registered bus lines up with it.
  always_comb begin
    bus_cyc_nx_s  = 1'b0;
    bus_we_nx_s   = 1'b0;
    bus_addr_nx_s = {AW{1'b0}};
    bus_data_nx_s = {DW{1'b0}};
    bus_sel_nx_s  = {SELW{1'b0}};
    bus_be_nx_s   = {BW{1'b0}};
    case (state_nx_s)
      ST_ACCESS: begin
        bus_cyc_nx_s  = 1'b1;
        bus_we_nx_s   = we_r;
        bus_addr_nx_s = paddr_nx_s;
        bus_sel_nx_s  = dsel_nx_s;
        bus_data_nx_s = we_r ? wdata_r : {DW{1'b0}};
`ifdef MMU_ARB_RMW_EN
        bus_be_nx_s   = {BW{1'b1}};
`else
        bus_be_nx_s   = we_r ? be_r : {BW{1'b1}};
`endif
      end
`ifdef MMU_ARB_RMW_EN
      ST_RMW_RD: begin
        bus_cyc_nx_s  = 1'b1;
        bus_addr_nx_s = paddr_nx_s;
        bus_sel_nx_s  = dsel_nx_s;
        bus_be_nx_s   = {BW{1'b1}};
      end
      ST_RMW_WR: begin
        bus_cyc_nx_s  = 1'b1;
        bus_we_nx_s   = 1'b1;
        bus_addr_nx_s = paddr_nx_s;
        bus_sel_nx_s  = dsel_nx_s;
        bus_data_nx_s = wbuf_nx_s;
        bus_be_nx_s   = {BW{1'b1}};
      end
`endif
      default: begin
        bus_cyc_nx_s  = 1'b0;
      end
    endcase
    ack_nx_s = {NPORT{1'b0}};
    if (state_r == ST_DONE) begin
      ack_nx_s[gnt_r] = 1'b1;
    end else begin
      ack_nx_s = {NPORT{1'b0}};
    end
  end

  // State, request buffer, bus registers and registered completion outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      gnt_r      <= {GW{1'b0}};
      we_r       <= 1'b0;
      vaddr_r    <= {AW{1'b0}};
      wdata_r    <= {DW{1'b0}};
      be_r       <= {BW{1'b0}};
      paddr_r    <= {AW{1'b0}};
      dsel_r     <= {SELW{1'b0}};
      rbuf_r     <= {DW{1'b0}};
      errb_r     <= 1'b0;
      cnt_r      <= {TW{1'b0}};
`ifdef MMU_ARB_RMW_EN
      wbuf_r     <= {DW{1'b0}};
`endif
      ack_r      <= {NPORT{1'b0}};
      err_r      <= 1'b0;
      rdata_r    <= {DW{1'b0}};
      bus_cyc_r  <= 1'b0;
      bus_we_r   <= 1'b0;
      bus_addr_r <= {AW{1'b0}};
      bus_data_r <= {DW{1'b0}};
      bus_sel_r  <= {SELW{1'b0}};
      bus_be_r   <= {BW{1'b0}};
    end else begin
      state_r <= state_nx_s;
      if ((state_r == ST_IDLE) && gnt_vld_s) begin
        gnt_r   <= gnt_s;
        we_r    <= we_i[gnt_s];
        vaddr_r <= sel_addr_s;
        wdata_r <= sel_wdata_s;
        be_r    <= sel_be_s;
      end
      paddr_r    <= paddr_nx_s;
      dsel_r     <= dsel_nx_s;
      rbuf_r     <= rbuf_nx_s;
      errb_r     <= errb_nx_s;
      cnt_r      <= cnt_nx_s;
`ifdef MMU_ARB_RMW_EN
      wbuf_r     <= wbuf_nx_s;
`endif
      ack_r      <= ack_nx_s;
      err_r      <= (state_r == ST_DONE) ? errb_r : 1'b0;
      rdata_r    <= (state_r == ST_DONE) ? rbuf_r : {DW{1'b0}};
      bus_cyc_r  <= bus_cyc_nx_s;
      bus_we_r   <= bus_we_nx_s;
      bus_addr_r <= bus_addr_nx_s;
      bus_data_r <= bus_data_nx_s;
      bus_sel_r  <= bus_sel_nx_s;
      bus_be_r   <= bus_be_nx_s;
    end
  end

  assign rdata_o     = rdata_r;
  assign ack_o       = ack_r;
  assign err_o       = err_r;
  assign stall_o     = req_i & ~ack_r;
  assign tlb_vaddr_o = vaddr_r;
  assign bus_cyc_o   = bus_cyc_r;
  assign bus_we_o    = bus_we_r;
  assign bus_addr_o  = bus_addr_r;
  assign bus_data_o  = bus_data_r;
  assign bus_sel_o   = bus_sel_r;
  assign bus_be_o    = bus_be_r;

endmodule
